// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state encoding and port indices for the memory arbiter
package mem_arb_pkg;
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] OWN0  = 2'd1;
   localparam logic [1:0] OWN1  = 2'd2;
   localparam logic [1:0] DRAIN = 2'd3;

   localparam int ICACHE = 0;
   localparam int DCACHE = 1;

   typedef enum logic [1:0] {
      ST_IDLE  = IDLE,
      ST_OWN0  = OWN0,
      ST_OWN1  = OWN1,
      ST_DRAIN = DRAIN
   } arb_state_t;
endpackage

// File: rtl/dff.sv
// rtl/dff.sv - parameterised register cell with asynchronous active-high reset
module dff #(
   parameter int           W       = 1,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) o_q <= RST_VAL;
      else       o_q <= i_d;
   end
endmodule

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - combinational 2-way round-robin chooser, one-hot result
module rr_pick2 (
   input  logic [1:0] i_req,
   input  logic       i_last,
   output logic [1:0] o_pick
);
   always_comb begin
      o_pick = i_req;
      // On a tie the port not served last wins.
      if (i_req == 2'b11) o_pick = i_last ? 2'b01 : 2'b10;
   end
endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port line-granular arbiter in front of the banked main memory
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW      = 16,
   parameter int DW      = 16,
   parameter int TIMEOUT = 64
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic [1:0]    i_req,
   input  logic [1:0]    i_rd,
   input  logic [1:0]    i_wr,
   input  logic [AW-1:0] i_addr0,
   input  logic [AW-1:0] i_addr1,
   input  logic [DW-1:0] i_wdata0,
   input  logic [DW-1:0] i_wdata1,
   output logic [1:0]    o_gnt,
   output logic [1:0]    o_stall,
   output logic [DW-1:0] o_rdata,
   output logic [AW-1:0] o_mem_addr,
   output logic [DW-1:0] o_mem_data_in,
   output logic          o_mem_read,
   output logic          o_mem_write,
   input  logic [DW-1:0] i_mem_data_out,
   input  logic          i_mem_stall,
   input  logic [3:0]    i_mem_busy,
   output logic          o_arb_err
);
   localparam logic [7:0] LP_TO_LAST = 8'(TIMEOUT - 1);

   logic [1:0] r_state, w_state_d;
   logic       r_last, w_last_d;
   logic [7:0] r_cnt, w_cnt_d;
   logic       r_err, w_err_d;

   arb_state_t w_state;
   logic [1:0] w_pick, w_arb_state, w_want;
   logic       w_own0, w_own1, w_own, w_own_rd, w_own_wr, w_drain_ok;

   dff #(.W(2), .RST_VAL(IDLE)) u_state (.i_clk(i_clk), .i_rst(i_rst), .i_d(w_state_d), .o_q(r_state));
   dff #(.W(1), .RST_VAL(1'b1)) u_last  (.i_clk(i_clk), .i_rst(i_rst), .i_d(w_last_d),  .o_q(r_last));
   dff #(.W(8), .RST_VAL(8'd0)) u_cnt   (.i_clk(i_clk), .i_rst(i_rst), .i_d(w_cnt_d),   .o_q(r_cnt));
   dff #(.W(1), .RST_VAL(1'b0)) u_err   (.i_clk(i_clk), .i_rst(i_rst), .i_d(w_err_d),   .o_q(r_err));

   rr_pick2 u_pick (.i_req(i_req), .i_last(r_last), .o_pick(w_pick));

   assign w_state     = arb_state_t'(r_state);
   assign w_own0      = (w_state == ST_OWN0);
   assign w_own1      = (w_state == ST_OWN1);
   assign w_own       = w_own0 | w_own1;
   assign w_drain_ok  = (i_mem_busy == 4'b0000) && !i_mem_stall;
   assign w_arb_state = w_pick[ICACHE] ? OWN0 : (w_pick[DCACHE] ? OWN1 : IDLE);
   assign w_want      = i_req | i_rd | i_wr;

   always_comb begin
      w_state_d = r_state;
      w_last_d  = r_last;
      case (w_state)
         ST_IDLE:  w_state_d = w_arb_state;
         ST_OWN0:  if (!i_req[ICACHE]) begin w_state_d = DRAIN; w_last_d = 1'b0; end
         ST_OWN1:  if (!i_req[DCACHE]) begin w_state_d = DRAIN; w_last_d = 1'b1; end
         ST_DRAIN: if (w_drain_ok) w_state_d = w_arb_state;
         default:  w_state_d = IDLE;
      endcase
   end

   // Count saturates so a stuck owner cannot wrap and miss the timeout again.
   assign w_cnt_d = w_own ? ((r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1) : 8'd0;
   assign w_err_d = r_err | (w_own & ((w_own_rd & w_own_wr) | (r_cnt == LP_TO_LAST)));

   assign w_own_rd = (w_own0 & i_rd[ICACHE]) | (w_own1 & i_rd[DCACHE]);
   assign w_own_wr = (w_own0 & i_wr[ICACHE]) | (w_own1 & i_wr[DCACHE]);

   assign o_gnt         = {w_own1, w_own0};
   assign o_mem_addr    = w_own0 ? i_addr0  : (w_own1 ? i_addr1  : '0);
   assign o_mem_data_in = w_own0 ? i_wdata0 : (w_own1 ? i_wdata1 : '0);
   assign o_mem_write   = w_own_wr;
   assign o_mem_read    = w_own_rd & ~w_own_wr;
   assign o_rdata       = i_mem_data_out;
   assign o_arb_err     = r_err;

   always_comb begin
      o_stall = w_want;
      if (i_rst)       o_stall = 2'b00;
      else if (w_own0) o_stall = {w_want[DCACHE], i_mem_stall};
      else if (w_own1) o_stall = {i_mem_stall, w_want[ICACHE]};
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed vector bench for mem_arbiter
module tb_mem_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req, rd, wr, gnt, stall;
   logic [15:0] addr0, addr1, wdata0, wdata1, rdata, mem_addr, mem_din, mem_dout;
   logic        mem_read, mem_write, mem_stall, arb_err;
   logic [3:0]  mem_busy;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.AW(16), .DW(16), .TIMEOUT(64)) dut (
      .i_clk(clk), .i_rst(rst), .i_req(req), .i_rd(rd), .i_wr(wr),
      .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
      .o_gnt(gnt), .o_stall(stall), .o_rdata(rdata),
      .o_mem_addr(mem_addr), .o_mem_data_in(mem_din),
      .o_mem_read(mem_read), .o_mem_write(mem_write),
      .i_mem_data_out(mem_dout), .i_mem_stall(mem_stall), .i_mem_busy(mem_busy),
      .o_arb_err(arb_err)
   );

   typedef struct {
      logic [1:0]  req, rd, wr;
      logic [15:0] a0, a1, d0, d1;
      logic [3:0]  busy;
      logic        mst;
      logic [15:0] mdo;
      logic [1:0]  gnt, stall;
      logic [15:0] maddr, mdin;
      logic        mrd, mwr;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(
      logic [1:0] q, logic [1:0] r, logic [1:0] w,
      logic [15:0] a0, logic [15:0] a1, logic [15:0] d0, logic [15:0] d1,
      logic [3:0] busy, logic mst, logic [15:0] mdo,
      logic [1:0] g, logic [1:0] s, logic [15:0] ma, logic [15:0] md,
      logic mr, logic mw);
      vec_t v;
      v.req = q; v.rd = r; v.wr = w; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
      v.busy = busy; v.mst = mst; v.mdo = mdo;
      v.gnt = g; v.stall = s; v.maddr = ma; v.mdin = md; v.mrd = mr; v.mwr = mw;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive_idle();
      req = 2'b00; rd = 2'b00; wr = 2'b00;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      mem_dout = '0; mem_stall = 1'b0; mem_busy = 4'b0000;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive_idle();
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic apply_vec(input int idx);
      vec_t v;
      logic [63:0] act, exp;
      v = tbl[idx];
      req = v.req; rd = v.rd; wr = v.wr;
      addr0 = v.a0; addr1 = v.a1; wdata0 = v.d0; wdata1 = v.d1;
      mem_busy = v.busy; mem_stall = v.mst; mem_dout = v.mdo;
      @(negedge clk);
      act = {9'd0, gnt, stall, mem_addr, mem_din, mem_read, mem_write, rdata, arb_err};
      exp = {9'd0, v.gnt, v.stall, v.maddr, v.mdin, v.mrd, v.mwr, v.mdo, 1'b0};
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL vec%0d: got gnt/stall/addr/din/rd/wr/rdata/err %h expected %h", idx, act, exp);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      //          req    rd     wr     a0       a1       d0       d1       busy     mst   mdo       gnt    stall  maddr    mdin     rd    wr
      tbl.push_back(mk(2'b00,2'b00,2'b00,16'h0000,16'h0000,16'h0000,16'h0000,4'b0000,1'b0,16'h0000, 2'b00,2'b00,16'h0000,16'h0000,1'b0,1'b0));
      tbl.push_back(mk(2'b01,2'b01,2'b00,16'h1230,16'h0000,16'h0000,16'h0000,4'b0000,1'b0,16'h0000, 2'b00,2'b01,16'h0000,16'h0000,1'b0,1'b0));
      tbl.push_back(mk(2'b01,2'b01,2'b00,16'h1230,16'h0000,16'h0000,16'h0000,4'b0000,1'b0,16'h0000, 2'b01,2'b00,16'h1230,16'h0000,1'b1,1'b0));
      tbl.push_back(mk(2'b01,2'b01,2'b00,16'h1232,16'h0000,16'h0000,16'h0000,4'b0000,1'b0,16'hBEEF, 2'b01,2'b00,16'h1232,16'h0000,1'b1,1'b0));
      tbl.push_back(mk(2'b01,2'b00,2'b00,16'h1232,16'h0000,16'h0000,16'h0000,4'b0000,1'b1,16'h0000, 2'b01,2'b01,16'h1232,16'h0000,1'b0,1'b0));
      tbl.push_back(mk(2'b00,2'b00,2'b00,16'h1232,16'h0000,16'h0000,16'h0000,4'b0000,1'b0,16'h0000, 2'b01,2'b00,16'h1232,16'h0000,1'b0,1'b0));
      tbl.push_back(mk(2'b00,2'b00,2'b00,16'h1232,16'h0000,16'h0000,16'h0000,4'b0000,1'b0,16'h0000, 2'b00,2'b00,16'h0000,16'h0000,1'b0,1'b0));
      tbl.push_back(mk(2'b11,2'b00,2'b10,16'h0000,16'h0500,16'h0000,16'h1111,4'b0000,1'b0,16'h0000, 2'b00,2'b11,16'h0000,16'h0000,1'b0,1'b0));
      tbl.push_back(mk(2'b11,2'b00,2'b11,16'h0040,16'h0500,16'h2222,16'h1111,4'b0000,1'b0,16'h0000, 2'b10,2'b01,16'h0500,16'h1111,1'b0,1'b1));
      tbl.push_back(mk(2'b11,2'b00,2'b01,16'h0040,16'h0500,16'h2222,16'h1111,4'b0000,1'b0,16'h0000, 2'b10,2'b01,16'h0500,16'h1111,1'b0,1'b0));
      tbl.push_back(mk(2'b01,2'b00,2'b01,16'h0040,16'h0500,16'h2222,16'h1111,4'b0100,1'b0,16'h0000, 2'b10,2'b01,16'h0500,16'h1111,1'b0,1'b0));
      for (int i = 0; i < 3; i++)
         tbl.push_back(mk(2'b01,2'b00,2'b01,16'h0040,16'h0500,16'h2222,16'h1111,4'b0100,1'b0,16'h0000, 2'b00,2'b01,16'h0000,16'h0000,1'b0,1'b0));
      tbl.push_back(mk(2'b01,2'b00,2'b01,16'h0040,16'h0500,16'h2222,16'h1111,4'b0000,1'b0,16'h0000, 2'b00,2'b01,16'h0000,16'h0000,1'b0,1'b0));
      tbl.push_back(mk(2'b01,2'b00,2'b01,16'h0040,16'h0500,16'h2222,16'h1111,4'b0000,1'b0,16'h0000, 2'b01,2'b00,16'h0040,16'h2222,1'b0,1'b1));
      tbl.push_back(mk(2'b00,2'b00,2'b00,16'h0040,16'h0000,16'h2222,16'h0000,4'b0000,1'b0,16'h0000, 2'b01,2'b00,16'h0040,16'h2222,1'b0,1'b0));
      tbl.push_back(mk(2'b10,2'b00,2'b00,16'h0000,16'h0600,16'h0000,16'h0000,4'b0000,1'b1,16'h0000, 2'b00,2'b10,16'h0000,16'h0000,1'b0,1'b0));
      tbl.push_back(mk(2'b10,2'b00,2'b00,16'h0000,16'h0600,16'h0000,16'h0000,4'b0000,1'b0,16'h0000, 2'b00,2'b10,16'h0000,16'h0000,1'b0,1'b0));
      tbl.push_back(mk(2'b10,2'b10,2'b00,16'h0000,16'h0600,16'h0000,16'h0000,4'b0000,1'b0,16'h5A5A, 2'b10,2'b00,16'h0600,16'h0000,1'b1,1'b0));
      tbl.push_back(mk(2'b00,2'b00,2'b00,16'h0000,16'h0600,16'h0000,16'h0000,4'b0000,1'b0,16'h0000, 2'b10,2'b00,16'h0600,16'h0000,1'b0,1'b0));
      tbl.push_back(mk(2'b10,2'b00,2'b00,16'h0000,16'h0600,16'h0000,16'h0000,4'b0000,1'b0,16'h0000, 2'b00,2'b10,16'h0000,16'h0000,1'b0,1'b0));
      tbl.push_back(mk(2'b11,2'b00,2'b00,16'h0000,16'h0600,16'h0000,16'h0000,4'b0000,1'b0,16'h0000, 2'b10,2'b01,16'h0600,16'h0000,1'b0,1'b0));
      tbl.push_back(mk(2'b01,2'b00,2'b00,16'h0000,16'h0600,16'h0000,16'h0000,4'b0000,1'b0,16'h0000, 2'b10,2'b01,16'h0600,16'h0000,1'b0,1'b0));
      tbl.push_back(mk(2'b01,2'b00,2'b00,16'h0123,16'h0600,16'h0000,16'h0000,4'b0000,1'b0,16'h0000, 2'b00,2'b01,16'h0000,16'h0000,1'b0,1'b0));
      tbl.push_back(mk(2'b01,2'b00,2'b00,16'h0123,16'h0600,16'h0000,16'h0000,4'b0000,1'b0,16'h0000, 2'b01,2'b00,16'h0123,16'h0000,1'b0,1'b0));
      tbl.push_back(mk(2'b00,2'b00,2'b00,16'h0123,16'h0600,16'h0000,16'h0000,4'b0000,1'b0,16'h0000, 2'b01,2'b00,16'h0123,16'h0000,1'b0,1'b0));
      tbl.push_back(mk(2'b00,2'b00,2'b00,16'h0123,16'h0600,16'h0000,16'h0000,4'b0000,1'b0,16'h0000, 2'b00,2'b00,16'h0000,16'h0000,1'b0,1'b0));

      rst = 1'b1;
      drive_idle();
      #2;
      chk("rst_gnt",   32'(gnt),       32'h0);
      chk("rst_stall", 32'(stall),     32'h0);
      chk("rst_mem",   {mem_addr, 14'd0, mem_read, mem_write}, 32'h0);
      chk("rst_err",   32'(arb_err),   32'h0);
      #10 rst = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < tbl.size(); i++) apply_vec(i);

      // Watchdog: error after 64 cycles of ownership, ownership kept, flag sticky.
      do_reset();
      req = 2'b01;
      repeat (64) @(posedge clk);
      @(negedge clk);
      chk("wd_err_before", 32'(arb_err), 32'h0);
      chk("wd_gnt_before", 32'(gnt),     32'h1);
      @(posedge clk);
      @(negedge clk);
      chk("wd_err_at", 32'(arb_err), 32'h1);
      chk("wd_gnt_at", 32'(gnt),     32'h1);
      req = 2'b00;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("wd_err_sticky", 32'(arb_err), 32'h1);
      chk("wd_gnt_idle",   32'(gnt),     32'h0);

      // Owner read+write together: forwarded as write, error raised.
      do_reset();
      req = 2'b01;
      @(posedge clk);
      #1 rd = 2'b01; wr = 2'b01; addr0 = 16'h0777;
      @(negedge clk);
      chk("rw_write", 32'(mem_write), 32'h1);
      chk("rw_read",  32'(mem_read),  32'h0);
      chk("rw_err0",  32'(arb_err),   32'h0);
      @(posedge clk);
      #1 rd = 2'b00; wr = 2'b00;
      @(negedge clk);
      chk("rw_err1", 32'(arb_err), 32'h1);

      // Asynchronous reset mid-burst during port 1 ownership.
      do_reset();
      req = 2'b10; rd = 2'b10; wr = 2'b10; addr1 = 16'h0900;
      @(posedge clk);
      @(negedge clk);
      chk("ar_gnt_own", 32'(gnt),       32'h2);
      chk("ar_wr_own",  32'(mem_write), 32'h1);
      @(posedge clk);
      #2 chk("ar_err_set", 32'(arb_err), 32'h1);
      #1 rst = 1'b1;
      #1;
      chk("ar_gnt",   32'(gnt),       32'h0);
      chk("ar_write", 32'(mem_write), 32'h0);
      chk("ar_err",   32'(arb_err),   32'h0);
      chk("ar_stall", 32'(stall),     32'h0);
      chk("ar_addr",  32'(mem_addr),  32'h0);
      #1 rst = 1'b0;
      req = 2'b11; rd = 2'b00; wr = 2'b00;
      @(posedge clk);
      @(negedge clk);
      chk("ar_tie_gnt",   32'(gnt),   32'h1);
      chk("ar_tie_stall", 32'(stall), 32'h2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
